nroot_shift_arbiter: RTL and testbench
======================================

# nroot_shift_arbiter

Shares one 25-bit left barrel shifter (5-stage 16/8/4/2/1 decomposition, shift amount 0-31, zero fill) between two requesters in the Nroot Method1 datapath. Each requester presents an operand and shift amount through a valid/ready handshake. The block grants round-robin, registers the operand, shifts it, and returns the tagged result through a valid/ready response port. It flags any set bit lost off the top. Only one operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 25, operand/result width; fixed at 25 to match the shared shifter.
- AMTW, 5, shift amount width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- req0_valid  input  1  requester 0 has an operand.
- req0_data  input  25  requester 0 operand.
- req0_amt  input  5  requester 0 left-shift amount.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid, req1_data, req1_amt, req1_ready: same as requester 0, for requester 1.
- resp_valid  output  1  result available.
- resp_id  output  1  requester that owns the result (0/1).
- resp_data  output  25  shifted operand, zero filled.
- resp_ovf  output  1  at least one '1' bit was shifted out past bit 24.
- resp_ready  input  1  consumer takes the result.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - Arbitrate among asserted reqN_valid.
  - When exactly one requester is valid, grant it.
  - When both are valid, grant the one not in last_grant.
  - reqN_ready is asserted combinationally for the granted requester only, and only in IDLE.
  - On grant, capture data, amt and id into op registers, set last_grant to the granted id, and go to SHIFT.
- SHIFT:
  - Op registers drive the shifter.
  - The result is registered into resp_data and the id into resp_id.
  - resp_ovf = 1 iff (op_data >> (25-amt)) != 0 for amt 1..24. It is 1 iff op_data != 0 for amt >= 25. It is 0 for amt = 0.
  - Go to DONE.
- DONE:
  - resp_valid = 1.
  - resp_data, resp_id and resp_ovf are held stable until resp_ready.
  - When resp_ready = 1, go to IDLE.
  - No new grant is issued in the DONE cycle.
- Shift amounts 25-31 produce resp_data = 0.
- last_grant resets to 1, so requester 0 wins the first contended arbitration.
- Requesters may drop valid without being granted; there is no penalty and no state change.
- Inputs of a non-granted requester are ignored.
- Reset output values:
  - req0_ready = 0, req1_ready = 0.
  - resp_valid = 0, resp_id = 0, resp_data = 0, resp_ovf = 0.
  - last_grant = 1.
- Reset mid-operation (SHIFT or DONE): the in-flight op is discarded, no response is produced, and the state returns to IDLE on the next edge.

## Timing
- Accept at edge N (valid & ready high in the cycle before N). SHIFT occupies cycle N to N+1. resp_valid is high from N+1.
- Minimum latency from accept to resp_valid: 1 cycle. Minimum initiation interval: 3 cycles (IDLE, SHIFT, DONE with resp_ready already high).
- resp_ready held high: resp_valid pulses for exactly one cycle per op.
- resp_ready low: DONE persists indefinitely and outputs are stable (backpressure).
- A request asserted while the block is in SHIFT or DONE waits. Its reqN_ready stays 0 until IDLE.
- Simultaneous events:
  - Both requesters valid in IDLE: single grant per the round-robin rule.
  - resp_ready and new requests in DONE: the response completes first; arbitration happens in the following IDLE cycle.
- No combinational path from resp_ready to reqN_ready.

## Test plan
- Reset then idle: rst high 2 cycles -> all outputs 0, both ready 0 while no valid. First req0 with req0_data=25'h000001, req0_amt=3 -> req0_ready=1, then 1 cycle later resp_valid=1, resp_data=25'h000008, resp_id=0, resp_ovf=0.
- Overflow/large shift:
  - data=25'h1000001, amt=1 -> resp_data=25'h0000002, ovf=1.
  - data=25'h0000001, amt=24 -> resp_data=25'h1000000, ovf=0.
  - data=25'h0000001, amt=31 -> resp_data=0, ovf=1.
  - data=0, amt=31 -> resp_data=0, ovf=0.
- Contention: both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 and resp_id follows. One response every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_data and resp_id stay stable. Both reqN_ready stay 0. Accept completes the cycle resp_ready=1.
- Reset mid-op: assert rst in the SHIFT cycle -> no resp_valid appears, state is IDLE, last_grant=1, and the next contended grant goes to requester 0.
- Random: 10k random requests with random valid/ready toggling, checked against a reference model of ((data<<amt) & 25'h1FFFFFF) and ovf. No response is lost or duplicated, and id ordering matches grant order.

Source files
------------

// File: rtl/nroot_shift_arbiter_if.sv
// rtl/nroot_shift_arbiter_if.sv - request/response bus for the shared shift arbiter
// Purpose: bundles both requester handshakes and the tagged response port.
// Signals:
//   reqN_valid/reqN_data/reqN_amt/reqN_ready (N = 0, 1) : operand + shift amount handshake
//   resp_valid/resp_id/resp_data/resp_ovf/resp_ready    : tagged shift result handshake
// Modports: master = requesters and result consumer, slave = arbiter.
interface nroot_shift_arbiter_if #(
  parameter int WIDTH = 25,
  parameter int AMTW  = 5
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic [AMTW-1:0]  req0_amt;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic [AMTW-1:0]  req1_amt;
  logic             req1_ready;
  logic             resp_valid;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_ovf;
  logic             resp_ready;

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    output req0_ready,
    input  req1_valid, req1_data, req1_amt,
    output req1_ready,
    output resp_valid, resp_id, resp_data, resp_ovf,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_data, req0_amt,
    input  req0_ready,
    output req1_valid, req1_data, req1_amt,
    input  req1_ready,
    input  resp_valid, resp_id, resp_data, resp_ovf,
    output resp_ready
  );
endinterface

// File: rtl/nroot_shift_arbiter.sv
// rtl/nroot_shift_arbiter.sv - round-robin arbiter around one shared 25-bit left barrel shifter
// Purpose: grants one of two requesters, shifts its operand left (zero fill, 0-31),
//          and returns the tagged result with an overflow flag. One op in flight.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : nroot_shift_arbiter_if.slave (request handshakes in, tagged response out)
module nroot_shift_arbiter #(
  parameter int WIDTH = 25,
  parameter int AMTW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  nroot_shift_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] op_data_q;
  logic [AMTW-1:0]  op_amt_q;
  logic             op_id_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_ovf_q;

  logic             grant0_d;
  logic             grant1_d;
  logic [WIDTH-1:0] shift_d;
  logic             ovf_d;

  // Grants are only offered in IDLE and never during reset, so nothing in
  // DONE (including resp_ready) can reach reqN_ready.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0_d = last_grant_q;
        grant1_d = ~last_grant_q;
      end else begin
        grant0_d = bus.req0_valid;
        grant1_d = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0_d;
  assign bus.req1_ready = grant1_d;

  // Five-stage barrel shifter. Each stage flags any set bit it pushes past
  // the top, so the OR of all stages is exactly "a 1 was lost", including
  // amounts 25-31 where every original bit leaves the word.
  always_comb begin
    logic [WIDTH-1:0] st;
    st    = op_data_q;
    ovf_d = 1'b0;
    if (op_amt_q[4]) begin
      ovf_d = ovf_d | (|st[WIDTH-1 -: 16]);
      st    = st << 16;
    end
    if (op_amt_q[3]) begin
      ovf_d = ovf_d | (|st[WIDTH-1 -: 8]);
      st    = st << 8;
    end
    if (op_amt_q[2]) begin
      ovf_d = ovf_d | (|st[WIDTH-1 -: 4]);
      st    = st << 4;
    end
    if (op_amt_q[1]) begin
      ovf_d = ovf_d | (|st[WIDTH-1 -: 2]);
      st    = st << 2;
    end
    if (op_amt_q[0]) begin
      ovf_d = ovf_d | st[WIDTH-1];
      st    = st << 1;
    end
    shift_d = st;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_data_q    <= '0;
      op_amt_q     <= '0;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0_d || grant1_d) begin
            op_data_q    <= grant1_d ? bus.req1_data : bus.req0_data;
            op_amt_q     <= grant1_d ? bus.req1_amt : bus.req0_amt;
            op_id_q      <= grant1_d;
            last_grant_q <= grant1_d;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          resp_data_q  <= shift_d;
          resp_id_q    <= op_id_q;
          resp_ovf_q   <= ovf_d;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          // Response fields stay frozen until the consumer takes them.
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_ovf   = resp_ovf_q;
endmodule

// File: tb/tb_nroot_shift_arbiter.sv
// tb/tb_nroot_shift_arbiter.sv - self-checking bench for nroot_shift_arbiter
module tb_nroot_shift_arbiter;
  typedef struct packed {
    logic        id;
    logic [24:0] data;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  nroot_shift_arbiter_if bus ();

  nroot_shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [24:0] ref_data(input logic [24:0] d, input logic [4:0] a);
    logic [63:0] wide;
    wide = {39'd0, d} << a;
    return wide[24:0];
  endfunction

  function automatic logic ref_ovf(input logic [24:0] d, input logic [4:0] a);
    logic [63:0] wide;
    wide = {39'd0, d} << a;
    return (wide >> 25) != 64'd0;
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req0_amt   = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.req1_amt   = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with resp_valid high (ok=1).
  task automatic issue(input logic id, input logic [24:0] d, input logic [4:0] a, output logic ok);
    logic got;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_amt = a;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_amt = a;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = id ? bus.req1_ready : bus.req0_ready;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (got) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        if (bus.resp_valid) got = 1'b1;
        else @(negedge clk);
      end
    end
    ok = got;
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_id !== 1'b0) begin n_fail++; $display("FAIL reset_resp_id got %b want 0", bus.resp_id); end
    n_cmp++; if (bus.resp_data !== 25'd0) begin n_fail++; $display("FAIL reset_resp_data got %h want 0", bus.resp_data); end
    n_cmp++; if (bus.resp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ovf got %b want 0", bus.resp_ovf); end
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {bus.req1_ready, bus.req0_ready}); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready got %b want 00", {bus.req1_ready, bus.req0_ready}); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_resp_valid got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 25'h000001; bus.req0_amt = 5'd3;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready0 got %b want 1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready1 got %b want 0", bus.req1_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_shift_valid got %b want 0", bus.resp_valid); end
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_resp_valid got %b want 1", bus.resp_valid); end
    n_cmp++; if (bus.resp_data !== 25'h000008) begin n_fail++; $display("FAIL basic_resp_data got %h want 000008", bus.resp_data); end
    n_cmp++; if (bus.resp_id !== 1'b0) begin n_fail++; $display("FAIL basic_resp_id got %b want 0", bus.resp_id); end
    n_cmp++; if (bus.resp_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_resp_ovf got %b want 0", bus.resp_ovf); end
    consume();
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_resp_drop got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_overflow();
    logic [24:0] vd [6] = '{25'h1000001, 25'h0000001, 25'h0000001, 25'h0000000, 25'h1FFFFFF, 25'h0000001};
    logic [4:0]  va [6] = '{5'd1, 5'd24, 5'd31, 5'd31, 5'd0, 5'd25};
    logic [24:0] ed [6] = '{25'h0000002, 25'h1000000, 25'h0000000, 25'h0000000, 25'h1FFFFFF, 25'h0000000};
    logic        eo [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic ok;
    for (int i = 0; i < 6; i++) begin
      issue(i[0], vd[i], va[i], ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_handshake[%0d] got %b want 1", i, ok); end
      n_cmp++; if (bus.resp_data !== ed[i]) begin n_fail++; $display("FAIL ovf_data[%0d] got %h want %h", i, bus.resp_data, ed[i]); end
      n_cmp++; if (bus.resp_ovf !== eo[i]) begin n_fail++; $display("FAIL ovf_flag[%0d] got %b want %b", i, bus.resp_ovf, eo[i]); end
      n_cmp++; if (bus.resp_id !== i[0]) begin n_fail++; $display("FAIL ovf_id[%0d] got %b want %b", i, bus.resp_id, i[0]); end
      consume();
    end
  endtask

  task automatic test_contention();
    int gc[$];
    int gid[$];
    int rid[$];
    pulse_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 25'($urandom); bus.req0_amt = 5'($urandom);
    bus.req1_valid = 1'b1; bus.req1_data = 25'($urandom); bus.req1_amt = 5'($urandom);
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_cmp++; if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin n_fail++; $display("FAIL cont_double_grant cycle %0d got 11 want single", c); end
      if (bus.req0_ready || bus.req1_ready) begin gc.push_back(c); gid.push_back(int'(bus.req1_ready)); end
      if (bus.resp_valid) rid.push_back(int'(bus.resp_id));
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b0;
    n_cmp++; if (gc.size() != 4) begin n_fail++; $display("FAIL cont_grant_count got %0d want 4", gc.size()); end
    n_cmp++; if (rid.size() != 4) begin n_fail++; $display("FAIL cont_resp_count got %0d want 4", rid.size()); end
    for (int i = 0; i < gc.size() && i < 4; i++) begin
      n_cmp++; if (gid[i] != i % 2) begin n_fail++; $display("FAIL cont_grant_id[%0d] got %0d want %0d", i, gid[i], i % 2); end
      if (i > 0) begin
        n_cmp++; if (gc[i] - gc[i-1] != 3) begin n_fail++; $display("FAIL cont_interval[%0d] got %0d want 3", i, gc[i] - gc[i-1]); end
      end
      if (i < rid.size()) begin
        n_cmp++; if (rid[i] != gid[i]) begin n_fail++; $display("FAIL cont_resp_id[%0d] got %0d want %0d", i, rid[i], gid[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [24:0] d;
    d = 25'h0ABCDE;
    issue(1'b1, d, 5'd4, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_handshake got %b want 1", ok); end
    n_cmp++; if (bus.resp_data !== ref_data(d, 5'd4)) begin n_fail++; $display("FAIL bp_data got %h want %h", bus.resp_data, ref_data(d, 5'd4)); end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", c, bus.resp_valid); end
      n_cmp++; if (bus.resp_data !== ref_data(d, 5'd4)) begin n_fail++; $display("FAIL bp_hold_data[%0d] got %h want %h", c, bus.resp_data, ref_data(d, 5'd4)); end
      n_cmp++; if (bus.resp_id !== 1'b1) begin n_fail++; $display("FAIL bp_hold_id[%0d] got %b want 1", c, bus.resp_id); end
      n_cmp++; if (bus.resp_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ovf[%0d] got %b want 0", c, bus.resp_ovf); end
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 00", c, {bus.req1_ready, bus.req0_ready}); end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_release_ready got %b want 00", {bus.req1_ready, bus.req0_ready}); end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid got %b want 0", bus.resp_valid); end
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_next_grant got %b want 01", {bus.req1_ready, bus.req0_ready}); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic ok;
    bus.req0_valid = 1'b1; bus.req0_data = 25'h000123; bus.req0_amt = 5'd2;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept got %b want 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp[%0d] got %b want 0", c, bus.resp_valid); end
      @(negedge clk);
    end
    bus.req0_valid = 1'b1; bus.req0_data = 25'h000005; bus.req0_amt = 5'd1;
    bus.req1_valid = 1'b1; bus.req1_data = 25'h000007; bus.req1_amt = 5'd1;
    #1;
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant got %b want 01", {bus.req1_ready, bus.req0_ready}); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 5 && !ok; c++) begin
      if (bus.resp_valid) ok = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_resp_timeout got %b want 1", ok); end
    n_cmp++; if (bus.resp_id !== 1'b0 || bus.resp_data !== 25'h00000A) begin n_fail++; $display("FAIL mid_resp got id %b data %h want id 0 data 00000a", bus.resp_id, bus.resp_data); end
    consume();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic lg;
    logic v0, v1, rr, g0, g1, erv, pop;
    int   age;
    int   accepted;
    int   cycles;
    localparam int N = 10000;
    pulse_reset();
    lg = 1'b1; age = 0; accepted = 0; cycles = 0;
    while ((accepted < N || q.size() != 0) && cycles < 90000) begin
      v0 = (accepted < N) && ($urandom % 4 != 0);
      v1 = (accepted < N) && ($urandom % 4 != 0);
      rr = ($urandom % 4 != 0);
      bus.req0_valid = v0; bus.req0_amt = 5'($urandom);
      bus.req0_data  = ($urandom % 8 == 0) ? 25'd0 : 25'($urandom >> ($urandom % 24));
      bus.req1_valid = v1; bus.req1_amt = 5'($urandom);
      bus.req1_data  = ($urandom % 8 == 0) ? 25'd0 : 25'($urandom >> ($urandom % 24));
      bus.resp_ready = rr;
      #1;
      g0  = (q.size() == 0) && v0 && (!v1 || lg);
      g1  = (q.size() == 0) && v1 && (!v0 || !lg);
      erv = (q.size() != 0) && (age >= 1);
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== {g1, g0}) begin n_fail++; $display("FAIL rnd_ready cycle %0d got %b want %b", cycles, {bus.req1_ready, bus.req0_ready}, {g1, g0}); end
      n_cmp++; if (bus.resp_valid !== erv) begin n_fail++; $display("FAIL rnd_resp_valid cycle %0d got %b want %b", cycles, bus.resp_valid, erv); end
      pop = 1'b0;
      if (erv && bus.resp_valid) begin
        n_cmp++; if ({bus.resp_id, bus.resp_data, bus.resp_ovf} !== q[0]) begin n_fail++; $display("FAIL rnd_resp cycle %0d got id %b data %h ovf %b want id %b data %h ovf %b", cycles, bus.resp_id, bus.resp_data, bus.resp_ovf, q[0].id, q[0].data, q[0].ovf); end
        pop = rr;
      end
      @(negedge clk);
      cycles++;
      age++;
      if (pop) void'(q.pop_front());
      if (g0 || g1) begin
        e.id   = g1;
        e.data = g1 ? ref_data(bus.req1_data, bus.req1_amt) : ref_data(bus.req0_data, bus.req0_amt);
        e.ovf  = g1 ? ref_ovf(bus.req1_data, bus.req1_amt) : ref_ovf(bus.req0_data, bus.req0_amt);
        q.push_back(e);
        lg = g1;
        age = 0;
        accepted++;
      end
    end
    idle_inputs();
    n_cmp++; if (accepted != N) begin n_fail++; $display("FAIL rnd_accept_count got %0d want %0d", accepted, N); end
    n_cmp++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_outstanding got %0d want 0", q.size()); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
